// File: rtl/full_subtractor_unit_pkg.sv
// Shared constants and result type for the registered ripple-borrow subtractor.
package full_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // {bout, diff} pair for a default-width subtraction
    typedef struct packed {
        logic                     bout;
        logic [DEFAULT_WIDTH-1:0] diff;
    } sub_result_t;

endpackage

// File: rtl/full_subtractor_unit_if.sv
// Operand/result bundle for full_subtractor_unit.
// The clr_sticky/sticky_bout pair exists only when FULL_SUBTRACTOR_STICKY_EN is defined.
interface full_subtractor_unit_if #(
    parameter int WIDTH = full_subtractor_pkg::DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef FULL_SUBTRACTOR_STICKY_EN
    logic             clr_sticky;
    logic             sticky_bout;

    modport master (
        output in_valid, a, b, bin, clr_sticky,
        input  out_valid, diff, bout, sticky_bout
    );

    modport slave (
        input  in_valid, a, b, bin, clr_sticky,
        output out_valid, diff, bout, sticky_bout
    );
`else
    modport master (
        output in_valid, a, b, bin,
        input  out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin,
        output out_valid, diff, bout
    );
`endif

endinterface

// File: rtl/full_subtractor_unit_cell.sv
// Purely combinational 1-bit full-subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor_unit.sv
// Registered ripple-borrow subtractor: {bout, diff} <= a - b - bin, one cycle latency.
// Optional sticky borrow flag enabled by defining FULL_SUBTRACTOR_STICKY_EN.
module full_subtractor_unit #(
    parameter int WIDTH = full_subtractor_pkg::DEFAULT_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    full_subtractor_unit_if.slave bus
);

    typedef struct packed {
        logic             bout;
        logic [WIDTH-1:0] diff;
    } result_t;

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_comb;
    result_t          result_q;
    logic             out_valid_q;

    assign borrow[0] = bus.bin;

    // Borrow ripples LSB to MSB through one cell per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .bin  (borrow[i]),
            .diff (diff_comb[i]),
            .bout (borrow[i+1])
        );
    end

    // Result registers load only on valid, so idle operands never reach them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q.bout <= borrow[WIDTH];
                result_q.diff <= diff_comb;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = result_q.diff;
    assign bus.bout      = result_q.bout;

`ifdef FULL_SUBTRACTOR_STICKY_EN
    logic sticky_q;

    // A new borrow takes priority over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (bus.in_valid && borrow[WIDTH]) begin
            sticky_q <= 1'b1;
        end else if (bus.clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.sticky_bout = sticky_q;
`endif

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Self-checking bench for full_subtractor_unit at WIDTH=1 and WIDTH=8.
// Sticky checks are compiled in when FULL_SUBTRACTOR_STICKY_EN is defined.
module tb_full_subtractor_unit;
    import full_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    sub_result_t truth_table [8];
    sub_result_t exp1;
    logic [7:0]  exp8_diff;
    logic        exp8_bout;

    full_subtractor_unit_if #(.WIDTH(1)) bus1 ();
    full_subtractor_unit_if #(.WIDTH(8)) bus8 ();

    full_subtractor_unit #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    full_subtractor_unit #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus1(input logic valid, input logic a, input logic b,
                                   input logic bin);
        bus1.in_valid = valid;
        bus1.a        = a;
        bus1.b        = b;
        bus1.bin      = bin;
    endtask

    task automatic apply_stimulus8(input logic valid, input logic [7:0] a,
                                   input logic [7:0] b, input logic bin);
        bus8.in_valid = valid;
        bus8.a        = a;
        bus8.b        = b;
        bus8.bin      = bin;
    endtask

    // Reference: plain integer subtraction, borrow from an unsigned comparison
    task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic bo);
        int r;
        r  = int'(a) - int'(b) - int'(bin);
        d  = r[7:0];
        bo = (int'(a) < int'(b) + int'(bin));
    endtask

    task automatic check1(input string tag, input logic valid, input sub_result_t e);
        check_output({tag, "_valid1"}, 32'(bus1.out_valid), 32'(valid));
        check_output({tag, "_diff1"},  32'(bus1.diff),      32'(e.diff));
        check_output({tag, "_bout1"},  32'(bus1.bout),      32'(e.bout));
    endtask

    task automatic check8(input string tag, input logic valid, input logic [7:0] d,
                          input logic bo);
        check_output({tag, "_valid8"}, 32'(bus8.out_valid), 32'(valid));
        check_output({tag, "_diff8"},  32'(bus8.diff),      32'(d));
        check_output({tag, "_bout8"},  32'(bus8.bout),      32'(bo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] idx;
        logic       v1, v8;
        logic [7:0] ra, rb;
        logic       rbin, r1a, r1b, r1bin;
        sub_result_t zero1;

        // {diff, bout} per {a,b,bin}, straight from the full-subtractor truth table
        truth_table[0] = '{bout: 1'b0, diff: 1'b0};
        truth_table[1] = '{bout: 1'b1, diff: 1'b1};
        truth_table[2] = '{bout: 1'b1, diff: 1'b1};
        truth_table[3] = '{bout: 1'b1, diff: 1'b0};
        truth_table[4] = '{bout: 1'b0, diff: 1'b1};
        truth_table[5] = '{bout: 1'b0, diff: 1'b0};
        truth_table[6] = '{bout: 1'b0, diff: 1'b0};
        truth_table[7] = '{bout: 1'b1, diff: 1'b1};
        zero1 = '{bout: 1'b0, diff: 1'b0};

        rst = 1'b1;
        apply_stimulus1(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus8(1'b0, 8'h00, 8'h00, 1'b0);
`ifdef FULL_SUBTRACTOR_STICKY_EN
        bus1.clr_sticky = 1'b0;
        bus8.clr_sticky = 1'b0;
`endif
        repeat (2) tick();
        check1("reset", 1'b0, zero1);
        check8("reset", 1'b0, 8'h00, 1'b0);
`ifdef FULL_SUBTRACTOR_STICKY_EN
        check_output("reset_sticky", 32'(bus1.sticky_bout), 32'd0);
`endif

        // Operand presented in the same cycle reset releases is captured
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus8(1'b1, 8'h05, 8'h07, 1'b0);
        tick();
        check8("w8_a", 1'b1, 8'hFE, 1'b1);
        @(negedge clk);
        apply_stimulus8(1'b1, 8'h10, 8'h01, 1'b1);
        tick();
        check8("w8_b", 1'b1, 8'h0E, 1'b0);
        @(negedge clk);
        apply_stimulus8(1'b0, 8'h00, 8'h00, 1'b0);

        // Exhaustive WIDTH=1, back-to-back valid operations
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            apply_stimulus1(1'b1, idx[2], idx[1], idx[0]);
            tick();
            check1($sformatf("tt%0d", i), 1'b1, truth_table[i]);
            @(negedge clk);
        end

        // Randomised traffic on both widths with gaps in in_valid
        exp1      = truth_table[7];
        exp8_diff = 8'h0E;
        exp8_bout = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v1    = 1'($urandom_range(0, 1));
            v8    = 1'($urandom_range(0, 1));
            r1a   = 1'($urandom);
            r1b   = 1'($urandom);
            r1bin = 1'($urandom);
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rbin  = 1'($urandom);
            apply_stimulus1(v1, r1a, r1b, r1bin);
            if (v8) apply_stimulus8(1'b1, ra, rb, rbin);
            else    apply_stimulus8(1'b0, 8'hxx, 8'hxx, 1'bx);
            if (v1) exp1 = truth_table[{r1a, r1b, r1bin}];
            if (v8) model8(ra, rb, rbin, exp8_diff, exp8_bout);
            tick();
            check1($sformatf("rnd%0d", i), v1, exp1);
            check8($sformatf("rnd%0d", i), v8, exp8_diff, exp8_bout);
            @(negedge clk);
        end
        apply_stimulus8(1'b0, 8'h00, 8'h00, 1'b0);

        // Hold: idle operands must not disturb the last result
        apply_stimulus1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check1("hold_op", 1'b1, truth_table[4]);
        @(negedge clk);
        apply_stimulus1(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("hold%0d", i), 1'b0, truth_table[4]);
        end

        // Asynchronous reset between edges clears outputs immediately
        @(negedge clk);
        apply_stimulus1(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check1("pre_rst", 1'b1, truth_table[2]);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst", 1'b0, zero1);
`ifdef FULL_SUBTRACTOR_STICKY_EN
        check_output("async_rst_sticky", 32'(bus1.sticky_bout), 32'd0);
`endif
        @(negedge clk);
        apply_stimulus1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check1("in_rst", 1'b0, zero1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check1("post_rst_idle", 1'b0, zero1);
        @(negedge clk);
        apply_stimulus1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check1("post_rst_op", 1'b1, truth_table[4]);

`ifdef FULL_SUBTRACTOR_STICKY_EN
        check_output("sticky_idle", 32'(bus1.sticky_bout), 32'd0);
        @(negedge clk);
        apply_stimulus1(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_output("sticky_set", 32'(bus1.sticky_bout), 32'd1);
        @(negedge clk);
        apply_stimulus1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("sticky_keep", 32'(bus1.sticky_bout), 32'd1);
        @(negedge clk);
        apply_stimulus1(1'b1, 1'b0, 1'b1, 1'b0);
        bus1.clr_sticky = 1'b1;
        tick();
        check_output("sticky_set_wins", 32'(bus1.sticky_bout), 32'd1);
        @(negedge clk);
        apply_stimulus1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("sticky_clr", 32'(bus1.sticky_bout), 32'd0);
        @(negedge clk);
        bus1.clr_sticky = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
